// File: rtl/ysyx_25060170_pkg.sv
// Shared IFU definitions: FSM encoding, reset fetch address and PC arithmetic helpers.
// Pure declarations, no timing or flow-control behaviour of its own.
package ysyx_25060170_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_WAIT  = 2'b01,
    ST_HOLD  = 2'b10
  } ifu_state_e;

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

  // Wraps modulo 2^32, so the word after 0xFFFF_FFFC is 0x0000_0000.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/ysyx_25060170_ifu_if.sv
// IFU-facing signal bundle: imem request/response, redirect from EXU/WBU, and IDU handoff.
// master = IFU side, slave = memory / pipeline environment side.
interface ysyx_25060170_ifu_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        inst_ready_i;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  redirect_valid,
    input  redirect_pc,
    output pc_o,
    output inst_o,
    output inst_valid_o,
    input  inst_ready_i
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_resp_valid,
    output imem_resp_data,
    output redirect_valid,
    output redirect_pc,
    input  pc_o,
    input  inst_o,
    input  inst_valid_o,
    output inst_ready_i
  );

endinterface

// File: rtl/ysyx_25060170_Reg.sv
// Width/reset-value parameterised register with write enable; one-cycle update latency.
// No flow control: loads d on any rising edge where we is high.
module ysyx_25060170_Reg #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ysyx_25060170_ifu.sv
// Instruction fetch unit: one outstanding imem request, 2-cycle request-to-decode with ready memory.
// Holds the fetched word until decode accepts; redirects drop in-flight fetches without retracting them.
module ysyx_25060170_ifu
  import ysyx_25060170_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ysyx_25060170_ifu_if.master        bus
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pc_we;
  logic [31:0] req_addr_q, req_addr_d;
  logic        req_addr_we;
  logic [31:0] pc_hold_q, pc_hold_d;
  logic        pc_hold_we;
  logic [31:0] inst_q, inst_d;
  logic        drop_q, drop_d;

  logic [31:0] redir_tgt;
  logic [31:0] hold_next;
  logic        req_fire;
  logic        inst_fire;

  assign redir_tgt = pc_align(bus.redirect_pc);
  assign hold_next = pc_incr(pc_hold_q);
  assign pc_hold_d = req_addr_q;

  // Request is gated by rst_n so nothing is offered to memory while reset is held.
  assign bus.imem_req_valid = (state_q == ST_FETCH) && rst_n;
  assign bus.imem_req_addr  = req_addr_q;
  assign bus.inst_valid_o   = (state_q == ST_HOLD) && !bus.redirect_valid;
  assign bus.pc_o           = pc_hold_q;
  assign bus.inst_o         = inst_q;

  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign inst_fire = bus.inst_valid_o && bus.inst_ready_i;

  ysyx_25060170_Reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (pc_we),
    .d     (pc_d),
    .q     (pc_q)
  );

  ysyx_25060170_Reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_req_addr_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (req_addr_we),
    .d     (req_addr_d),
    .q     (req_addr_q)
  );

  ysyx_25060170_Reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc_hold_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (pc_hold_we),
    .d     (pc_hold_d),
    .q     (pc_hold_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      inst_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_we       = 1'b0;
    req_addr_d  = req_addr_q;
    req_addr_we = 1'b0;
    pc_hold_we  = 1'b0;
    inst_d      = inst_q;
    drop_d      = drop_q;

    case (state_q)
      ST_FETCH: begin
        if (req_fire) begin
          state_d = ST_WAIT;
        end
        // The pending request keeps its address; its response is marked for discard instead.
        if (bus.redirect_valid) begin
          pc_d   = redir_tgt;
          pc_we  = 1'b1;
          drop_d = 1'b1;
        end
      end

      ST_WAIT: begin
        if (bus.imem_resp_valid) begin
          if (bus.redirect_valid) begin
            // Response belongs to the old path; the new target wins outright.
            pc_d        = redir_tgt;
            pc_we       = 1'b1;
            req_addr_d  = redir_tgt;
            req_addr_we = 1'b1;
            drop_d      = 1'b0;
            state_d     = ST_FETCH;
          end else if (drop_q) begin
            req_addr_d  = pc_q;
            req_addr_we = 1'b1;
            drop_d      = 1'b0;
            state_d     = ST_FETCH;
          end else begin
            inst_d     = bus.imem_resp_data;
            pc_hold_we = 1'b1;
            state_d    = ST_HOLD;
          end
        end else if (bus.redirect_valid) begin
          pc_d   = redir_tgt;
          pc_we  = 1'b1;
          drop_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (bus.redirect_valid) begin
          pc_d        = redir_tgt;
          pc_we       = 1'b1;
          req_addr_d  = redir_tgt;
          req_addr_we = 1'b1;
          state_d     = ST_FETCH;
        end else if (inst_fire) begin
          pc_d        = hold_next;
          pc_we       = 1'b1;
          req_addr_d  = hold_next;
          req_addr_we = 1'b1;
          state_d     = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
// Directed, table-driven bench for the IFU: per-cycle input/expected-output rows plus hand sequences.
module tb_ysyx_25060170_ifu;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ysyx_25060170_ifu_if bus();

  ysyx_25060170_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rr;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        rdr_v;
    logic [31:0] rdr_pc;
    logic        ir;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  function automatic vec_t mk(input logic rr, input logic rsp_v, input logic [31:0] rsp_d,
                              input logic rdr_v, input logic [31:0] rdr_pc, input logic ir,
                              input logic e_rv, input logic [31:0] e_addr,
                              input logic e_iv, input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.rr = rr; v.rsp_v = rsp_v; v.rsp_d = rsp_d; v.rdr_v = rdr_v; v.rdr_pc = rdr_pc; v.ir = ir;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller is at a falling edge; drive, settle, compare, then advance to the next falling edge.
  task automatic apply(input vec_t v, input string tag);
    bus.imem_req_ready  = v.rr;
    bus.imem_resp_valid = v.rsp_v;
    bus.imem_resp_data  = v.rsp_d;
    bus.redirect_valid  = v.rdr_v;
    bus.redirect_pc     = v.rdr_pc;
    bus.inst_ready_i    = v.ir;
    #1;
    check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'(v.e_rv));
    if (v.e_rv) check({tag, "_req_addr"}, bus.imem_req_addr, v.e_addr);
    check({tag, "_inst_valid"}, 32'(bus.inst_valid_o), 32'(v.e_iv));
    if (v.e_iv) begin
      check({tag, "_pc_o"}, bus.pc_o, v.e_pc);
      check({tag, "_inst_o"}, bus.inst_o, v.e_inst);
    end
    @(negedge clk);
  endtask

  vec_t tbl [28];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.inst_ready_i    = 1'b0;

    //             rr rv  rsp_d         rdr rdr_pc        ir  e_rv e_addr        e_iv e_pc          e_inst
    tbl[0]  = mk(1, 0, 32'h0,         0, 32'h0,         0,  1, 32'h8000_0000, 0, 32'h0,         32'h0);
    tbl[1]  = mk(1, 1, 32'h0010_0093, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         32'h0);
    tbl[2]  = mk(1, 0, 32'h0,         0, 32'h0,         1,  0, 32'h0,         1, 32'h8000_0000, 32'h0010_0093);
    tbl[3]  = mk(0, 1, 32'hDEAD_0001, 0, 32'h0,         0,  1, 32'h8000_0004, 0, 32'h0,         32'h0);
    tbl[4]  = mk(0, 0, 32'h0,         0, 32'h0,         0,  1, 32'h8000_0004, 0, 32'h0,         32'h0);
    tbl[5]  = mk(0, 0, 32'h0,         0, 32'h0,         0,  1, 32'h8000_0004, 0, 32'h0,         32'h0);
    tbl[6]  = mk(1, 0, 32'h0,         0, 32'h0,         0,  1, 32'h8000_0004, 0, 32'h0,         32'h0);
    tbl[7]  = mk(1, 0, 32'h0,         0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         32'h0);
    tbl[8]  = mk(0, 1, 32'h0020_8113, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         32'h0);
    tbl[9]  = mk(1, 1, 32'hDEAD_BEEF, 0, 32'h0,         0,  0, 32'h0,         1, 32'h8000_0004, 32'h0020_8113);
    tbl[10] = mk(1, 0, 32'h0,         0, 32'h0,         0,  0, 32'h0,         1, 32'h8000_0004, 32'h0020_8113);
    tbl[11] = mk(1, 0, 32'h0,         0, 32'h0,         0,  0, 32'h0,         1, 32'h8000_0004, 32'h0020_8113);
    tbl[12] = mk(1, 0, 32'h0,         0, 32'h0,         0,  0, 32'h0,         1, 32'h8000_0004, 32'h0020_8113);
    tbl[13] = mk(1, 0, 32'h0,         0, 32'h0,         0,  0, 32'h0,         1, 32'h8000_0004, 32'h0020_8113);
    tbl[14] = mk(1, 0, 32'h0,         0, 32'h0,         1,  0, 32'h0,         1, 32'h8000_0004, 32'h0020_8113);
    tbl[15] = mk(1, 0, 32'h0,         0, 32'h0,         0,  1, 32'h8000_0008, 0, 32'h0,         32'h0);
    tbl[16] = mk(0, 0, 32'h0,         1, 32'h8000_0102, 0,  0, 32'h0,         0, 32'h0,         32'h0);
    tbl[17] = mk(0, 1, 32'hBAD0_0001, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         32'h0);
    tbl[18] = mk(1, 0, 32'h0,         0, 32'h0,         0,  1, 32'h8000_0100, 0, 32'h0,         32'h0);
    tbl[19] = mk(0, 1, 32'h0000_0013, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         32'h0);
    tbl[20] = mk(0, 0, 32'h0,         1, 32'h8000_0200, 1,  0, 32'h0,         0, 32'h0,         32'h0);
    tbl[21] = mk(0, 0, 32'h0,         0, 32'h0,         0,  1, 32'h8000_0200, 0, 32'h0,         32'h0);
    tbl[22] = mk(1, 0, 32'h0,         1, 32'h8000_0300, 0,  1, 32'h8000_0200, 0, 32'h0,         32'h0);
    tbl[23] = mk(0, 1, 32'hBAD0_0002, 1, 32'h8000_0401, 0,  0, 32'h0,         0, 32'h0,         32'h0);
    tbl[24] = mk(1, 0, 32'h0,         0, 32'h0,         0,  1, 32'h8000_0400, 0, 32'h0,         32'h0);
    tbl[25] = mk(0, 1, 32'h0040_0513, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         32'h0);
    tbl[26] = mk(0, 0, 32'h0,         0, 32'h0,         1,  0, 32'h0,         1, 32'h8000_0400, 32'h0040_0513);
    tbl[27] = mk(0, 0, 32'h0,         0, 32'h0,         0,  1, 32'h8000_0404, 0, 32'h0,         32'h0);

    // Reset values while rst_n is held low.
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check("rst_inst_valid", 32'(bus.inst_valid_o), 32'h0);
    check("rst_req_addr", bus.imem_req_addr, 32'h8000_0000);
    check("rst_pc_o", bus.pc_o, 32'h8000_0000);
    check("rst_inst_o", bus.inst_o, 32'h0);

    // Release on a falling edge so row 0 observes the very first post-reset cycle.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 28; i++) begin
      apply(tbl[i], $sformatf("row%0d", i));
    end

    // Redirect to the top word and check the PC wraps past 0xFFFF_FFFC.
    apply(mk(1, 0, 32'h0,         1, 32'hFFFF_FFFF, 0, 1, 32'h8000_0404, 0, 32'h0,         32'h0),         "wrap0");
    apply(mk(0, 1, 32'hBAD0_0003, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         32'h0),         "wrap1");
    apply(mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0),         "wrap2");
    apply(mk(0, 1, 32'h0000_0073, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         32'h0),         "wrap3");
    apply(mk(0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'h0000_0073), "wrap4");
    apply(mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0000, 0, 32'h0,         32'h0),         "wrap5");

    // Reset pulse while a request to 0x0 is outstanding; its late response must be ignored.
    rst_n = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hBADB_AD01;
    bus.inst_ready_i    = 1'b0;
    #1;
    check("midrst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check("midrst_inst_valid", 32'(bus.inst_valid_o), 32'h0);
    check("midrst_pc_o", bus.pc_o, 32'h8000_0000);
    check("midrst_inst_o", bus.inst_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(0, 1, 32'hBADB_AD02, 0, 32'h0, 0, 1, 32'h8000_0000, 0, 32'h0,         32'h0),         "post0");
    apply(mk(1, 0, 32'h0,         0, 32'h0, 0, 1, 32'h8000_0000, 0, 32'h0,         32'h0),         "post1");
    apply(mk(0, 1, 32'h0010_0093, 0, 32'h0, 0, 0, 32'h0,         0, 32'h0,         32'h0),         "post2");
    apply(mk(0, 0, 32'h0,         0, 32'h0, 1, 0, 32'h0,         1, 32'h8000_0000, 32'h0010_0093), "post3");
    apply(mk(0, 0, 32'h0,         0, 32'h0, 0, 1, 32'h8000_0004, 0, 32'h0,         32'h0),         "post4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
